// File: rtl/coin_encoder.sv
// coin_encoder: vending front end. Synchronizes and debounces the three coin
// sensors, queues detected coins in a small FIFO and issues each one as a
// one-cycle 2-bit code followed by idle cycles, holding coins while the credit
// FSM deasserts enable.
// Optional feature: define COIN_ENCODER_TOTAL_EN to get a saturating running
// credit total on total_value; otherwise total_value is tied to zero.
module coin_encoder #(
    parameter int DEBOUNCE   = 4,
    parameter int GAP        = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          sense_circle,
    input  logic                          sense_triangle,
    input  logic                          sense_pentagon,
    input  logic                          enable,
    output logic [1:0]                    coin,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [7:0]                    total_value
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0]       DEB_LAST   = 4'(DEBOUNCE - 1);
    localparam logic [3:0]       GAP_LOAD   = 4'(GAP - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_GAP
    } state_t;

    // Channel index: 0 circle, 1 triangle, 2 pentagon (also push priority order).
    logic [2:0] rawSense;
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;

    logic [3:0] dbCnt_q [3];
    logic [3:0] dbCnt_d [3];
    logic [2:0] armed_q;
    logic [2:0] armed_d;
    logic [2:0] detect;

    logic [2:0] pending_q;
    logic [2:0] pending_d;
    logic [2:0] selMask;
    logic [1:0] pushCode;
    logic       havePend;
    logic       fifoFull;
    logic       fifoEmpty;
    logic       doPop;
    logic       doPush;
    logic       doDrop;

    logic [1:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic [1:0]       headCode;

    state_t     state_q;
    logic [1:0] coin_q;
    logic [3:0] gapCnt_q;

    assign rawSense = {sense_pentagon, sense_triangle, sense_circle};
    assign headCode = mem_q[rdPtr_q];

    // Two-flop synchronizer per sensor; only the second stage feeds the debouncers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= rawSense;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: armed channels count highs to fire, disarmed channels count lows to re-arm.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            dbCnt_d[i] = dbCnt_q[i];
            armed_d[i] = armed_q[i];
            detect[i]  = 1'b0;
            if (armed_q[i]) begin
                if (sync2_q[i]) begin
                    if (dbCnt_q[i] == DEB_LAST) begin
                        detect[i]  = 1'b1;
                        armed_d[i] = 1'b0;
                        dbCnt_d[i] = 4'd0;
                    end else begin
                        dbCnt_d[i] = dbCnt_q[i] + 4'd1;
                    end
                end else begin
                    dbCnt_d[i] = 4'd0;
                end
            end else begin
                if (!sync2_q[i]) begin
                    if (dbCnt_q[i] == DEB_LAST) begin
                        armed_d[i] = 1'b1;
                        dbCnt_d[i] = 4'd0;
                    end else begin
                        dbCnt_d[i] = dbCnt_q[i] + 4'd1;
                    end
                end else begin
                    dbCnt_d[i] = 4'd0;
                end
            end
        end
    end

    // Debounce state registers; every channel starts armed with a cleared count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                dbCnt_q[i] <= 4'd0;
            end
            armed_q <= 3'b111;
        end else begin
            for (int i = 0; i < 3; i++) begin
                dbCnt_q[i] <= dbCnt_d[i];
            end
            armed_q <= armed_d;
        end
    end

    // Pick the highest-priority pending coin and decide push, drop or pop; a pop frees a full slot.
    always_comb begin
        selMask  = 3'b000;
        pushCode = 2'b00;
        if (pending_q[2]) begin
            selMask  = 3'b100;
            pushCode = 2'b11;
        end else if (pending_q[1]) begin
            selMask  = 3'b010;
            pushCode = 2'b10;
        end else if (pending_q[0]) begin
            selMask  = 3'b001;
            pushCode = 2'b01;
        end
        havePend  = |pending_q;
        fifoFull  = (count_q == FULL_COUNT);
        fifoEmpty = (count_q == '0);
        doPop     = (state_q == ST_IDLE) && !fifoEmpty && enable;
        doPush    = havePend && (!fifoFull || doPop);
        doDrop    = havePend && fifoFull && !doPop;
        pending_d = (pending_q & ~selMask) | detect;
    end

    // Pending bits, FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= 3'b000;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (doDrop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clock) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushCode;
        end
    end

    // Issue FSM: the IDLE cycle before the next pop is itself idle, so GAP state lasts GAP-1 cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            coin_q   <= 2'b00;
            gapCnt_q <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (doPop) begin
                        coin_q  <= headCode;
                        state_q <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    coin_q <= 2'b00;
                    if (GAP_LOAD == 4'd0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gapCnt_q <= GAP_LOAD;
                        state_q  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    coin_q   <= 2'b00;
                    gapCnt_q <= gapCnt_q - 4'd1;
                    if (gapCnt_q == 4'd1) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    coin_q  <= 2'b00;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign coin       = coin_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

`ifdef COIN_ENCODER_TOTAL_EN
    logic [7:0] total_q;
    logic [7:0] popValue;
    logic [8:0] totalSum;

    // Credit value of the coin being issued and the unsaturated running sum.
    always_comb begin
        case (headCode)
            2'b01:   popValue = 8'd1;
            2'b10:   popValue = 8'd3;
            2'b11:   popValue = 8'd5;
            default: popValue = 8'd0;
        endcase
        totalSum = {1'b0, total_q} + {1'b0, popValue};
    end

    // Running credit total, updated in the cycle a code is placed on coin, saturating at 255.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            total_q <= 8'd0;
        end else if (doPop) begin
            total_q <= totalSum[8] ? 8'hFF : totalSum[7:0];
        end
    end

    assign total_value = total_q;
`else
    assign total_value = 8'd0;
`endif

endmodule

// File: tb/tb_coin_encoder.sv
// tb_coin_encoder: scoreboard bench for coin_encoder. A reference model turns
// the driven sensor levels into the expected coin sequence; a monitor compares
// every issued code against it. Directed scenarios plus randomized insertions.
module tb_coin_encoder;

    localparam int DEBOUNCE   = 4;
    localparam int GAP        = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    logic             clock    = 1'b0;
    logic             reset_n  = 1'b0;
    logic             enable   = 1'b0;
    logic [2:0]       senseVec = 3'b000;
    logic [1:0]       coin;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;
    logic [7:0]       total_value;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    coin_encoder #(
        .DEBOUNCE   (DEBOUNCE),
        .GAP        (GAP),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .sense_circle   (senseVec[0]),
        .sense_triangle (senseVec[1]),
        .sense_pentagon (senseVec[2]),
        .enable         (enable),
        .coin           (coin),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .total_value    (total_value)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Drive one cycle of sensor levels and enable, changed just after a rising edge.
    task automatic applyStimulus(input logic [2:0] s, input logic en);
        @(posedge clock);
        #1;
        senseVec = s;
        enable   = en;
    endtask

    // ---------------- reference model ----------------
    // Sensor levels reach the debouncers two samples late. A channel waiting
    // for a coin needs DEBOUNCE straight high samples; afterwards it waits for
    // DEBOUNCE straight low samples before it can accept another. Detected
    // coins wait in a pending set and enter the queue one per cycle, largest
    // denomination first; with the queue full and no pop possible the coin is lost.
    int   expQ[$];
    bit   expOverflow;
    int   streak[3];
    bit   waitingForCoin[3];
    bit   pend[3];
    logic [2:0] seenPrev1;
    logic [2:0] seenPrev2;

    always @(posedge clock) begin : refModel
        int top;
        if (!reset_n) begin
            expQ.delete();
            expOverflow = 1'b0;
            seenPrev1   = 3'b000;
            seenPrev2   = 3'b000;
            for (int k = 0; k < 3; k++) begin
                streak[k]         = 0;
                waitingForCoin[k] = 1'b1;
                pend[k]           = 1'b0;
            end
        end else begin
            top = -1;
            for (int k = 2; k >= 0; k--) begin
                if (pend[k] && top < 0) top = k;
            end
            if (top >= 0) begin
                pend[top] = 1'b0;
                if (expQ.size() >= FIFO_DEPTH && !enable) expOverflow = 1'b1;
                else expQ.push_back(top + 1);
            end
            for (int k = 0; k < 3; k++) begin
                if (seenPrev2[k] == waitingForCoin[k]) begin
                    streak[k]++;
                    if (streak[k] == DEBOUNCE) begin
                        if (waitingForCoin[k]) pend[k] = 1'b1;
                        waitingForCoin[k] = !waitingForCoin[k];
                        streak[k] = 0;
                    end
                end else begin
                    streak[k] = 0;
                end
            end
            seenPrev2 = seenPrev1;
            seenPrev1 = senseVec;
        end
    end

    // ---------------- monitor ----------------
    int         codesSeen     = 0;
    int         lastCodeCycle = -1;
    int         codeCycles[$];
    int         codeVals[$];
    logic [1:0] prevCoin      = 2'b00;
    int         expTotal      = 0;

    always @(negedge clock) begin : monitor
        int expCode;
        if (!reset_n) begin
            lastCodeCycle = -1;
            expTotal      = 0;
        end else if (coin != 2'b00) begin
            codesSeen++;
            codeCycles.push_back(cycle);
            codeVals.push_back(int'(coin));
            if (expQ.size() == 0) begin
                checkOutput("unexpected_code", int'(coin), 0);
            end else begin
                expCode = expQ.pop_front();
                checkOutput("code_value", int'(coin), expCode);
`ifdef COIN_ENCODER_TOTAL_EN
                expTotal = expTotal + ((expCode == 1) ? 1 : (expCode == 2) ? 3 : 5);
                if (expTotal > 255) expTotal = 255;
                checkOutput("total_value", int'(total_value), expTotal);
`else
                checkOutput("total_value_zero", int'(total_value), 0);
`endif
            end
            checkOutput("code_one_cycle", int'(prevCoin), 0);
            if (lastCodeCycle >= 0)
                checkOutput("code_spacing_ok", int'((cycle - lastCodeCycle) >= GAP + 1), 1);
            lastCodeCycle = cycle;
        end
        prevCoin = coin;
    end

    // ---------------- stimulus ----------------
    bit waveArr[3][32];

    initial begin : stimulus
        int base;
        int n;
        int found;
        int bouncePat[7];
        int t;
        int mask;

        bouncePat = '{1, 1, 0, 1, 1, 1, 0};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_coin", int'(coin), 0);
        checkOutput("reset_fifo_count", int'(fifo_count), 0);
        checkOutput("reset_overflow", int'(overflow), 0);
        checkOutput("reset_total", int'(total_value), 0);
        reset_n = 1'b1;
        repeat (5) applyStimulus(3'b000, 1'b1);

        // Clean insertion with exact latency: first sampled at edge k, code after edge k+DEBOUNCE+3
        base = codesSeen;
        @(posedge clock);
        #1;
        senseVec = 3'b001;
        repeat (DEBOUNCE + 4) @(posedge clock);
        #1;
        checkOutput("latency_code", int'(coin), 1);
        @(posedge clock);
        #1;
        checkOutput("latency_code_cleared", int'(coin), 0);
        repeat (20 - (DEBOUNCE + 5)) @(posedge clock);
        #1;
        senseVec = 3'b000;
        repeat (15) applyStimulus(3'b000, 1'b1);
        checkOutput("clean_single_coin", codesSeen - base, 1);
        checkOutput("clean_fifo_empty", int'(fifo_count), 0);

        // Bounce rejection, then a clean triangle
        base = codesSeen;
        for (int i = 0; i < 7; i++) applyStimulus({1'b0, bouncePat[i] != 0, 1'b0}, 1'b1);
        repeat (12) applyStimulus(3'b000, 1'b1);
        checkOutput("bounce_no_code", codesSeen - base, 0);
        checkOutput("bounce_no_overflow", int'(overflow), 0);
        repeat (10) applyStimulus(3'b010, 1'b1);
        repeat (15) applyStimulus(3'b000, 1'b1);
        checkOutput("bounce_then_clean", codesSeen - base, 1);
        n = codeVals.size();
        if (n > 0) checkOutput("bounce_clean_code", codeVals[n-1], 2);

        // Simultaneous sensors
        base = codesSeen;
        repeat (10) applyStimulus(3'b111, 1'b1);
        repeat (25) applyStimulus(3'b000, 1'b1);
        checkOutput("simul_count", codesSeen - base, 3);
        n = codeVals.size();
        if (codesSeen - base == 3) begin
            checkOutput("simul_first", codeVals[n-3], 3);
            checkOutput("simul_second", codeVals[n-2], 2);
            checkOutput("simul_third", codeVals[n-1], 1);
            checkOutput("simul_spacing_a", codeCycles[n-2] - codeCycles[n-3], GAP + 1);
            checkOutput("simul_spacing_b", codeCycles[n-1] - codeCycles[n-2], GAP + 1);
        end

        // Backpressure and overflow
        base = codesSeen;
        for (int c = 0; c < 6; c++) begin
            repeat (8) applyStimulus(3'b001, 1'b0);
            repeat (8) applyStimulus(3'b000, 1'b0);
        end
        repeat (5) applyStimulus(3'b000, 1'b0);
        checkOutput("hold_no_code", codesSeen - base, 0);
        checkOutput("full_count", int'(fifo_count), FIFO_DEPTH);
        checkOutput("overflow_set", int'(overflow), 1);
        checkOutput("model_overflow", int'(overflow), int'(expOverflow));
        repeat (25) applyStimulus(3'b000, 1'b1);
        checkOutput("drain_count", codesSeen - base, 4);
        n = codeCycles.size();
        if (codesSeen - base == 4) begin
            for (int j = 1; j < 4; j++)
                checkOutput("drain_spacing", codeCycles[n-4+j] - codeCycles[n-5+j], GAP + 1);
        end
        checkOutput("drain_fifo_empty", int'(fifo_count), 0);
        checkOutput("overflow_sticky", int'(overflow), 1);

        // Reset mid-operation during GAP
        repeat (8) applyStimulus(3'b111, 1'b0);
        repeat (10) applyStimulus(3'b000, 1'b0);
        checkOutput("queued_three", int'(fifo_count), 3);
        enable = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(posedge clock);
            #1;
            if (coin != 2'b00) found = 1;
        end
        checkOutput("reset_test_first_code", found, 1);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_coin", int'(coin), 0);
        checkOutput("midreset_fifo_count", int'(fifo_count), 0);
        checkOutput("midreset_overflow", int'(overflow), 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        base = codesSeen;
        repeat (30) applyStimulus(3'b000, 1'b1);
        checkOutput("after_reset_silent", codesSeen - base, 0);

`ifdef COIN_ENCODER_TOTAL_EN
        // Saturating total: 52 pentagons
        base = codesSeen;
        for (int c = 0; c < 52; c++) begin
            repeat (6) applyStimulus(3'b100, 1'b1);
            repeat (6) applyStimulus(3'b000, 1'b1);
        end
        repeat (20) applyStimulus(3'b000, 1'b1);
        checkOutput("pentagon_count", codesSeen - base, 52);
        checkOutput("total_saturated", int'(total_value), 255);
`endif

        // Randomized insertions with bounce and random enable
        for (int ev = 0; ev < 20; ev++) begin
            for (int k = 0; k < 3; k++)
                for (int j = 0; j < 32; j++) waveArr[k][j] = 1'b0;
            mask = int'($urandom_range(1, 7));
            for (int k = 0; k < 3; k++) begin
                if (mask[k]) begin
                    t = int'($urandom_range(0, 2));
                    n = int'($urandom_range(0, 5));
                    for (int j = 0; j < n; j++) begin
                        waveArr[k][t] = ($urandom_range(0, 1) == 1);
                        t++;
                    end
                    n = int'($urandom_range(DEBOUNCE, DEBOUNCE + 6));
                    for (int j = 0; j < n; j++) begin
                        waveArr[k][t] = 1'b1;
                        t++;
                    end
                end
            end
            for (int j = 0; j < 32; j++)
                applyStimulus({waveArr[2][j], waveArr[1][j], waveArr[0][j]}, $urandom_range(0, 3) != 0);
            repeat (20) applyStimulus(3'b000, 1'b1);
        end
        checkOutput("random_all_delivered", expQ.size(), 0);
        checkOutput("random_no_overflow", int'(overflow), 0);
        checkOutput("random_fifo_empty", int'(fifo_count), 0);
`ifndef COIN_ENCODER_TOTAL_EN
        checkOutput("total_zero_end", int'(total_value), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
